fix2tfp_sched: RTL and testbench
================================

// Module: fix2tfp_sched
// PURPOSE
//  Shares one pipelined fix2tfp converter between NCH fixed-point requesters.
//  Picks one request per cycle by round-robin and tags each sample with its channel.
//  Returns results as a single tagged stream with valid/ready backpressure.
//  Sits between the per-channel fixed-point sources and the tfp packing/storage logic.
// PARAMETERS
//  TFP_WIDTH  8  width of trivial float-point word
//  EXP_WIDTH  3  width of exponent field in tfp word
//  PIPELINE   0  latency of the internal fix2tfp, clock cycles (>=0)
//  NCH        4  number of requesters (>=1)
//  FIX_WIDTH = TFP_WIDTH-EXP_WIDTH+2**EXP_WIDTH-1; TAG_WIDTH = max(1,$clog2(NCH)) (derived)
// PORTS
//  rst        in   1              reset, synchronous, active-high
//  clk        in   1              clock
//  inp_data   in   NCH*FIX_WIDTH  per-channel fixed-point data, channel i at [i*FIX_WIDTH +: FIX_WIDTH]
//  inp_valid  in   NCH            per-channel request valid
//  inp_ready  out  NCH            per-channel accept; one-hot or zero
//  out_data   out  TFP_WIDTH      converted tfp word
//  out_chan   out  TAG_WIDTH      channel index of out_data
//  out_valid  out  1              result valid
//  out_ready  in   1              downstream accept
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Valid chain: an issue register followed by PIPELINE tag/valid stages. The tag/valid stages run alongside fix2tfp.
//  - Latency from accept (inp_valid&inp_ready) to out_valid is 1+PIPELINE cycles.
//  - adv = ~out_valid | out_ready. adv drives the converter clkena and every stage enable.
//  - Stall is global. Bubbles are not collapsed.
//  - inp_ready[i] = adv & grant[i] & ~rst, and is combinational.
//  - Grant goes to the first valid channel at or after ptr, searching upward modulo NCH.
//  - On accept, ptr becomes the granted index + 1, wrapping NCH-1 to 0. Otherwise ptr holds.
//  - Idle channels are skipped with no lost cycle. A single active channel gets 1 sample/clk.
//  - Throughput is 1 sample/clk while out_ready=1.
//  - While out_valid=1 and out_ready=0: out_data, out_chan and out_valid hold stable, and all inp_ready are 0.
//  - Samples are never dropped or duplicated. Per-channel order is preserved.
//  - out_data is a function of the sampled fix word only, and equals a standalone fix2tfp with the same parameters.
//  - Reset values: out_valid=0, out_chan=0, out_data=0 (issue data reset to 0), ptr=0, inp_ready=0.
//  - Reset mid-operation discards all in-flight samples. No stale result appears after release.
//  - inp_valid may change freely while not accepted. No per-channel stickiness is required.
// CONFIGURATION
//  FIX2TFP_SCHED_STAT_EN defined:
//   - Adds ports stat_cnt out [NCH*32] and stat_clr in 1.
//   - stat_cnt: per-channel count of results taken (out_valid&out_ready), 32-bit wrap.
//   - stat_clr is synchronous. When it coincides with a take, the count becomes 0.
//   - rst clears all counts.
//  Not defined: no ports and no counter logic. All other behaviour is identical.
// STRUCTURE
//  - Package fix2tfp_pkg holds fix_width(TFP_WIDTH,EXP_WIDTH) and tag_width(NCH).
//    fix2tfp, tfp2fix and this block all use it.
//  - Sub-module fix2tfp_rr_arb (NCH): inputs req, ptr. Output one-hot grant. Purely combinational.
//  - Instance the_fix2tfp: the existing converter, with clkena=adv.
// TESTING  (TFP_WIDTH=8, EXP_WIDTH=3 -> FIX_WIDTH=12, NCH=4, PIPELINE=2, latency 3)
//  1. ch0 only, data 12'h000, out_ready=1
//     -> inp_ready[0]=1 same cycle; 3 clks later out_valid=1, out_chan=0, out_data=8'h00, for 1 clk.
//  2. All 4 valid continuously, out_ready=1
//     -> grants 0,1,2,3,0,1...; out_chan follows the same sequence 3 clks later; one result per clk.
//  3. Pipe full, then out_ready=0 for 5 clks
//     -> inp_ready=4'b0000; outputs frozen; after release the sequence continues with no loss or duplicate.
//  4. Only ch1 and ch3 valid
//     -> grants alternate 1,3,1,3 with no idle cycles; ptr skips 0 and 2.
//  5. rst high for 1 clk with 3 samples in flight
//     -> next clk out_valid=0, ptr=0; first post-reset grant goes to the lowest valid channel.
//  6. ch2 sweeps 0..4095 under random out_ready
//     -> every out_data matches a reference fix2tfp, and tfp2fix(out_data) matches a reference round trip.

Source files
------------

// File: rtl/fix2tfp_pkg.sv
// Shared sizing helpers for the fix2tfp converter family (fix2tfp, tfp2fix, fix2tfp_sched).
package fix2tfp_pkg;

  // Fixed-point width that a tfp word with the given exponent field can represent exactly.
  function automatic int fix_width(input int tfp_w, input int exp_w);
    return tfp_w - exp_w + (2 ** exp_w) - 1;
  endfunction

  function automatic int tag_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/fix2tfp.sv
// Unsigned fixed-point to trivial float-point {exp, mant} converter (value = mant << exp, truncating),
// with PIPELINE output registers advanced by clkena.
module fix2tfp
  import fix2tfp_pkg::*;
#(
  parameter  int TFP_WIDTH = 8,
  parameter  int EXP_WIDTH = 3,
  parameter  int PIPELINE  = 0,
  localparam int FIX_WIDTH = fix_width(TFP_WIDTH, EXP_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clkena,
  input  logic [FIX_WIDTH-1:0] fix_in,
  output logic [TFP_WIDTH-1:0] tfp_out
);

  localparam int          MANT_W  = TFP_WIDTH - EXP_WIDTH;
  localparam int unsigned EXP_MAX = (2 ** EXP_WIDTH) - 1;
  localparam int unsigned NSTG    = PIPELINE;

  logic [EXP_WIDTH-1:0] w_exp;
  logic [MANT_W-1:0]    w_mant;
  logic [TFP_WIDTH-1:0] w_tfp;

  // Smallest exponent whose shifted value fits the mantissa field.
  always_comb begin
    w_exp = '0;
    for (int unsigned k = 0; k < EXP_MAX; k++) begin
      if ((fix_in >> k) > FIX_WIDTH'((2 ** MANT_W) - 1)) w_exp = EXP_WIDTH'(k + 1);
    end
    w_mant = MANT_W'(fix_in >> w_exp);
    w_tfp  = {w_exp, w_mant};
  end

  if (PIPELINE == 0) begin : g_comb
    logic w_unused;
    assign w_unused = clk ^ rst ^ clkena;
    assign tfp_out  = w_tfp;
  end else begin : g_pipe
    logic [TFP_WIDTH-1:0] r_pipe [NSTG];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned s = 0; s < NSTG; s++) r_pipe[s] <= '0;
      end else if (clkena) begin
        r_pipe[0] <= w_tfp;
        for (int unsigned s = 1; s < NSTG; s++) r_pipe[s] <= r_pipe[s-1];
      end
    end
    assign tfp_out = r_pipe[NSTG-1];
  end

endmodule

// File: rtl/fix2tfp_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr, modulo NCH.
module fix2tfp_rr_arb
  import fix2tfp_pkg::*;
#(
  parameter  int NCH       = 4,
  localparam int TAG_WIDTH = tag_width(NCH)
) (
  input  logic [NCH-1:0]       req,
  input  logic [TAG_WIDTH-1:0] ptr,
  output logic [NCH-1:0]       grant
);

  localparam int unsigned N = NCH;

  int unsigned w_idx;
  logic        w_found;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = (32'(ptr) + i) % N;
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fix2tfp_sched.sv
// Round-robin scheduler sharing one pipelined fix2tfp between NCH requesters, tagged output stream.
// Optional per-channel take counters: define FIX2TFP_SCHED_STAT_EN.
module fix2tfp_sched
  import fix2tfp_pkg::*;
#(
  parameter  int TFP_WIDTH = 8,
  parameter  int EXP_WIDTH = 3,
  parameter  int PIPELINE  = 0,
  parameter  int NCH       = 4,
  localparam int FIX_WIDTH = fix_width(TFP_WIDTH, EXP_WIDTH),
  localparam int TAG_WIDTH = tag_width(NCH)
) (
  input  logic                     rst,
  input  logic                     clk,
  input  logic [NCH*FIX_WIDTH-1:0] inp_data,
  input  logic [NCH-1:0]           inp_valid,
  output logic [NCH-1:0]           inp_ready,
  output logic [TFP_WIDTH-1:0]     out_data,
  output logic [TAG_WIDTH-1:0]     out_chan,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef FIX2TFP_SCHED_STAT_EN
  ,
  output logic [NCH*32-1:0]        stat_cnt,
  input  logic                     stat_clr
`endif
);

  localparam int unsigned N    = NCH;
  localparam int unsigned NSTG = PIPELINE + 1;

  logic                 w_adv;
  logic                 w_accept;
  logic [NCH-1:0]       w_grant;
  logic [TAG_WIDTH-1:0] w_gidx;
  logic [FIX_WIDTH-1:0] w_sel;
  logic [TAG_WIDTH-1:0] r_ptr;
  logic [FIX_WIDTH-1:0] r_iss_data;
  logic [NSTG-1:0]      r_vld;
  logic [TAG_WIDTH-1:0] r_tag [NSTG];

  assign w_adv = ~out_valid | out_ready;

  fix2tfp_rr_arb #(.NCH(NCH)) u_arb (
    .req   (inp_valid),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  assign inp_ready = (w_adv && !rst) ? w_grant : '0;
  assign w_accept  = |inp_ready;

  always_comb begin
    w_gidx = '0;
    w_sel  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_gidx = TAG_WIDTH'(i);
        w_sel  = inp_data[i*FIX_WIDTH +: FIX_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= (w_gidx == TAG_WIDTH'(NCH - 1)) ? '0 : w_gidx + 1'b1;
    end
  end

  // Stage 0 is the issue register; stages 1..PIPELINE shadow the converter pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < NSTG; s++) begin
        r_vld[s] <= 1'b0;
        r_tag[s] <= '0;
      end
      r_iss_data <= '0;
    end else if (w_adv) begin
      r_vld[0]   <= w_accept;
      r_tag[0]   <= w_gidx;
      r_iss_data <= w_sel;
      for (int unsigned s = 1; s < NSTG; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  fix2tfp #(
    .TFP_WIDTH (TFP_WIDTH),
    .EXP_WIDTH (EXP_WIDTH),
    .PIPELINE  (PIPELINE)
  ) the_fix2tfp (
    .clk     (clk),
    .rst     (rst),
    .clkena  (w_adv),
    .fix_in  (r_iss_data),
    .tfp_out (out_data)
  );

  assign out_valid = r_vld[NSTG-1];
  assign out_chan  = r_tag[NSTG-1];

`ifdef FIX2TFP_SCHED_STAT_EN
  logic        w_take;
  logic [31:0] r_stat [NCH];

  assign w_take = out_valid & out_ready;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (rst || stat_clr) begin
        r_stat[i] <= '0;
      end else if (w_take && (out_chan == TAG_WIDTH'(i))) begin
        r_stat[i] <= r_stat[i] + 32'd1;
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int unsigned i = 0; i < N; i++) stat_cnt[i*32 +: 32] = r_stat[i];
  end
`endif

endmodule

// File: tb/tb_fix2tfp_sched.sv
// Directed bench for fix2tfp_sched: TFP 8/3 (FIX 12), NCH=4, PIPELINE=2 (latency 3).
module tb_fix2tfp_sched;

  logic        clk;
  logic        rst;
  logic [47:0] inp_data;
  logic [3:0]  inp_valid;
  logic [3:0]  inp_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  int n_vec;
  int n_err;

  logic [7:0]  exp_tfp [4];
  logic [11:0] q_fix [$];

  fix2tfp_sched #(
    .TFP_WIDTH (8),
    .EXP_WIDTH (3),
    .PIPELINE  (2),
    .NCH       (4)
  ) dut (
    .rst       (rst),
    .clk       (clk),
    .inp_data  (inp_data),
    .inp_valid (inp_valid),
    .inp_ready (inp_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  // Reference converter: locate the MSB, keep the top 5 bits.
  function automatic logic [7:0] ref_tfp(input logic [11:0] f);
    int msb;
    int e;
    msb = -1;
    for (int b = 0; b < 12; b++) if (f[b]) msb = b;
    if (msb < 5) return {3'd0, f[4:0]};
    e = msb - 4;
    return {3'(e), 5'(f >> e)};
  endfunction

  function automatic logic [11:0] ref_rt(input logic [11:0] f);
    int msb;
    logic [11:0] mask;
    msb = -1;
    for (int b = 0; b < 12; b++) if (f[b]) msb = b;
    if (msb < 5) return f;
    mask = 12'hFFF << (msb - 4);
    return f & mask;
  endfunction

  function automatic logic [11:0] tfp2fix(input logic [7:0] t);
    logic [11:0] m;
    m = {7'd0, t[4:0]};
    return m << t[7:5];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    inp_valid = 4'hF;
    tick();
    @(negedge clk);
    chk("rst_inp_ready", 32'(inp_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_chan",  32'(out_chan),  32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    tick();
    rst       = 1'b0;
    inp_valid = 4'h0;
  endtask

  initial begin
    logic [11:0] fx;
    int          v;
    int          cyc;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    inp_data  = '0;
    inp_valid = '0;
    out_ready = 1'b1;
    exp_tfp[0] = 8'h01;
    exp_tfp[1] = 8'h30;
    exp_tfp[2] = 8'h7F;
    exp_tfp[3] = 8'hFF;

    // 1: single sample on ch0, latency 3
    do_reset();
    inp_data  = {12'hFFF, 12'h0FF, 12'h020, 12'h000};
    inp_valid = 4'b0001;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t1_ready", 32'(inp_ready), 32'h1);
    tick();
    inp_valid = 4'b0000;
    @(negedge clk); chk("t1_lat1", 32'(out_valid), 32'h0);
    tick();
    @(negedge clk); chk("t1_lat2", 32'(out_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_chan",  32'(out_chan),  32'h0);
    chk("t1_data",  32'(out_data),  32'h00);
    tick();
    @(negedge clk); chk("t1_once", 32'(out_valid), 32'h0);

    // 2: all channels valid, full rate
    do_reset();
    inp_data  = {12'hFFF, 12'h0FF, 12'h020, 12'h001};
    inp_valid = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t2_grant", 32'(inp_ready), 32'(1 << (k % 4)));
      if (k >= 3) begin
        chk("t2_valid", 32'(out_valid), 32'h1);
        chk("t2_chan",  32'(out_chan),  32'((k - 3) % 4));
        chk("t2_data",  32'(out_data),  32'(exp_tfp[(k - 3) % 4]));
      end else begin
        chk("t2_fill", 32'(out_valid), 32'h0);
      end
      tick();
    end

    // 3: stall with pipe full, then resume
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("t3_ready0", 32'(inp_ready), 32'h0);
      chk("t3_valid",  32'(out_valid), 32'h1);
      chk("t3_chan",   32'(out_chan),  32'h1);
      chk("t3_data",   32'(out_data),  32'h30);
      tick();
    end
    out_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      chk("t3_rvalid", 32'(out_valid), 32'h1);
      chk("t3_rchan",  32'(out_chan),  32'((1 + r) % 4));
      chk("t3_rdata",  32'(out_data),  32'(exp_tfp[(1 + r) % 4]));
      chk("t3_rgrant", 32'(inp_ready), 32'(1 << (r % 4)));
      tick();
    end

    // 4: ch1 and ch3 only
    do_reset();
    inp_valid = 4'b1010;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("t4_grant", 32'(inp_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
      if (k >= 3) begin
        chk("t4_valid", 32'(out_valid), 32'h1);
        chk("t4_chan",  32'(out_chan),  ((k - 3) % 2 == 0) ? 32'h1 : 32'h3);
        chk("t4_data",  32'(out_data),  ((k - 3) % 2 == 0) ? 32'h30 : 32'hFF);
      end
      tick();
    end

    // 5: reset with samples in flight (ptr is 2 here)
    rst = 1'b1;
    @(negedge clk); chk("t5_rdy_in_rst", 32'(inp_ready), 32'h0);
    tick();
    rst       = 1'b0;
    inp_valid = 4'hF;
    @(negedge clk);
    chk("t5_flushed", 32'(out_valid), 32'h0);
    chk("t5_ptr0",    32'(inp_ready), 32'h1);
    tick();
    inp_valid = 4'h0;
    @(negedge clk); chk("t5_stale1", 32'(out_valid), 32'h0);
    tick();
    @(negedge clk); chk("t5_stale2", 32'(out_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("t5_valid", 32'(out_valid), 32'h1);
    chk("t5_chan",  32'(out_chan),  32'h0);
    chk("t5_data",  32'(out_data),  32'h01);
    tick();
    @(negedge clk); chk("t5_once", 32'(out_valid), 32'h0);

    // 6: ch2 sweep under random backpressure
    do_reset();
    v   = 0;
    cyc = 0;
    q_fix.delete();
    while ((v < 4096 || q_fix.size() != 0) && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      inp_valid = (v < 4096) ? 4'b0100 : 4'b0000;
      inp_data  = '0;
      inp_data[24 +: 12] = 12'(v);
      @(negedge clk);
      if (out_valid && !out_ready) chk("t6_hold_ready", 32'(inp_ready), 32'h0);
      if (out_valid && out_ready) begin
        if (q_fix.size() == 0) begin
          chk("t6_extra", 32'h1, 32'h0);
        end else begin
          fx = q_fix.pop_front();
          chk("t6_chan", 32'(out_chan), 32'h2);
          chk("t6_data", 32'(out_data), 32'(ref_tfp(fx)));
          chk("t6_rt",   32'(tfp2fix(out_data)), 32'(ref_rt(fx)));
        end
      end
      if ((inp_valid & inp_ready) != 4'b0000) begin
        q_fix.push_back(12'(v));
        v++;
      end
      tick();
      cyc++;
    end
    chk("t6_drained", 32'((v == 4096) && (q_fix.size() == 0)), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
